// File: rtl/logic_gates.sv
// logic_gates: bitwise two-input gate stage (AND/OR/NOT/NAND/NOR/XOR/XNOR)
// with all results registered together, an enable for sampling, and a
// valid flag that rises on the first enabled capture after reset.
module logic_gates #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic             iEn,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic [WIDTH-1:0] oAnd,
  output logic [WIDTH-1:0] oOr,
  output logic [WIDTH-1:0] oNot,
  output logic [WIDTH-1:0] oNand,
  output logic [WIDTH-1:0] oNor,
  output logic [WIDTH-1:0] oXor,
  output logic [WIDTH-1:0] oXnor,
  output logic             oValid
);

  logic [WIDTH-1:0] andNext;
  logic [WIDTH-1:0] orNext;
  logic [WIDTH-1:0] notNext;
  logic [WIDTH-1:0] nandNext;
  logic [WIDTH-1:0] norNext;
  logic [WIDTH-1:0] xorNext;
  logic [WIDTH-1:0] xnorNext;

  // Combinational gate functions of the current operands.
  always_comb begin
    andNext  = iA & iB;
    orNext   = iA | iB;
    notNext  = ~iA;
    nandNext = ~(iA & iB);
    norNext  = ~(iA | iB);
    xorNext  = iA ^ iB;
    xnorNext = ~(iA ^ iB);
  end

  // Result registers: cleared (including the inverting outputs) on reset,
  // loaded together when enabled, otherwise held.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oAnd   <= '0;
      oOr    <= '0;
      oNot   <= '0;
      oNand  <= '0;
      oNor   <= '0;
      oXor   <= '0;
      oXnor  <= '0;
      oValid <= 1'b0;
    end else if (iEn) begin
      oAnd   <= andNext;
      oOr    <= orNext;
      oNot   <= notNext;
      oNand  <= nandNext;
      oNor   <= norNext;
      oXor   <= xorNext;
      oXnor  <= xnorNext;
      oValid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_logic_gates.sv
// Directed and random checks for logic_gates at WIDTH=1 and WIDTH=8.
module tb_logic_gates;

  logic clk = 1'b0;
  logic rstN;

  logic en1, a1, b1;
  logic and1, or1, not1, nand1, nor1, xor1, xnor1, valid1;

  logic       en8;
  logic [7:0] a8, b8;
  logic [7:0] and8, or8, not8, nand8, nor8, xor8, xnor8;
  logic       valid8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  logic_gates #(.WIDTH(1)) dut1 (
    .iClk(clk), .iRst_n(rstN), .iEn(en1), .iA(a1), .iB(b1),
    .oAnd(and1), .oOr(or1), .oNot(not1), .oNand(nand1), .oNor(nor1),
    .oXor(xor1), .oXnor(xnor1), .oValid(valid1)
  );

  logic_gates #(.WIDTH(8)) dut8 (
    .iClk(clk), .iRst_n(rstN), .iEn(en8), .iA(a8), .iB(b8),
    .oAnd(and8), .oOr(or8), .oNot(not8), .oNand(nand8), .oNor(nor8),
    .oXor(xor8), .oXnor(xnor8), .oValid(valid8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Width-1 DUT: expected and/or/not/xor/valid given; complements derived here.
  task automatic chk1(input string tag, input logic eAnd, input logic eOr,
                      input logic eNot, input logic eXor, input logic eValid);
    logic eNand, eNor, eXnor;
    eNand = ~eAnd;
    eNor  = ~eOr;
    eXnor = ~eXor;
    chk({tag, ".and"},   32'(and1),   32'(eAnd));
    chk({tag, ".or"},    32'(or1),    32'(eOr));
    chk({tag, ".not"},   32'(not1),   32'(eNot));
    chk({tag, ".xor"},   32'(xor1),   32'(eXor));
    chk({tag, ".nand"},  32'(nand1),  32'(eNand));
    chk({tag, ".nor"},   32'(nor1),   32'(eNor));
    chk({tag, ".xnor"},  32'(xnor1),  32'(eXnor));
    chk({tag, ".valid"}, 32'(valid1), 32'(eValid));
  endtask

  task automatic zero1(input string tag);
    chk({tag, ".and"},   32'(and1),   32'd0);
    chk({tag, ".or"},    32'(or1),    32'd0);
    chk({tag, ".not"},   32'(not1),   32'd0);
    chk({tag, ".nand"},  32'(nand1),  32'd0);
    chk({tag, ".nor"},   32'(nor1),   32'd0);
    chk({tag, ".xor"},   32'(xor1),   32'd0);
    chk({tag, ".xnor"},  32'(xnor1),  32'd0);
    chk({tag, ".valid"}, 32'(valid1), 32'd0);
  endtask

  task automatic zero8(input string tag);
    chk({tag, ".and8"},   32'(and8),   32'd0);
    chk({tag, ".or8"},    32'(or8),    32'd0);
    chk({tag, ".not8"},   32'(not8),   32'd0);
    chk({tag, ".nand8"},  32'(nand8),  32'd0);
    chk({tag, ".nor8"},   32'(nor8),   32'd0);
    chk({tag, ".xor8"},   32'(xor8),   32'd0);
    chk({tag, ".xnor8"},  32'(xnor8),  32'd0);
    chk({tag, ".valid8"}, 32'(valid8), 32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Truth-table sweep vectors with hand-computed and/or/not/xor.
  logic swA   [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic swB   [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  logic swAnd [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic swOr  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic swNot [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic swXor [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};

  logic [7:0] mAnd, mOr, mNot, mNand, mNor, mXor, mXnor;
  logic       mValid;
  logic [7:0] ra, rb;
  logic       ren;
  logic       prevA;

  initial begin
    rstN = 1'b0;
    en1 = 1'b0; a1 = 1'b0; b1 = 1'b0;
    en8 = 1'b0; a8 = '0;   b8 = '0;

    // Reset state
    tick();
    tick();
    zero1("rst");
    zero8("rst");

    // Release with enable low: nothing captured yet
    @(negedge clk);
    rstN = 1'b1;
    a1 = 1'b1; b1 = 1'b1;
    tick();
    zero1("rel_noen");

    // Truth-table sweep, each vector held 4 cycles
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      en1 = 1'b1; a1 = swA[i]; b1 = swB[i];
      tick();
      chk1($sformatf("tt%0d", i), swAnd[i], swOr[i], swNot[i], swXor[i], 1'b1);
      repeat (3) tick();
      chk1($sformatf("tt%0d_hold", i), swAnd[i], swOr[i], swNot[i], swXor[i], 1'b1);
    end

    // Asynchronous reset mid-operation with iA=iB=1
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b1;
    en8 = 1'b1; a8 = 8'hA5; b8 = 8'h0F;
    tick();
    chk1("pre_rst", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("pre_rst.and8", 32'(and8), 32'h05);
    #2;
    rstN = 1'b0;
    #1;
    zero1("async_rst");
    zero8("async_rst");
    tick();
    zero1("rst_held");
    @(negedge clk);
    rstN = 1'b1;
    en1 = 1'b0; en8 = 1'b0;
    tick();
    zero1("post_rel");
    zero8("post_rel");
    @(negedge clk);
    en1 = 1'b1;
    tick();
    chk1("first_cap", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    // Enable hold
    @(negedge clk);
    a1 = 1'b1; b1 = 1'b0; en1 = 1'b1;
    tick();
    @(negedge clk);
    en1 = 1'b0; a1 = 1'b0; b1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk1($sformatf("hold%0d", i), 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    end

    // Latency: oNot tracks the inverse of the previous cycle's iA
    @(negedge clk);
    en1 = 1'b1; b1 = 1'b0; a1 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      prevA = a1;
      tick();
      chk($sformatf("lat%0d", i), 32'(not1), 32'(!prevA));
      @(negedge clk);
      a1 = ~a1;
      #1;
      chk($sformatf("lat_mid%0d", i), 32'(not1), 32'(!prevA));
    end

    // Wide operands
    @(negedge clk);
    en8 = 1'b1; a8 = 8'hF0; b8 = 8'h3C;
    tick();
    chk("w.and",   32'(and8),   32'h30);
    chk("w.or",    32'(or8),    32'hFC);
    chk("w.not",   32'(not8),   32'h0F);
    chk("w.xor",   32'(xor8),   32'hCC);
    chk("w.nand",  32'(nand8),  32'hCF);
    chk("w.nor",   32'(nor8),   32'h03);
    chk("w.xnor",  32'(xnor8),  32'h33);
    chk("w.valid", 32'(valid8), 32'h1);

    // Random vectors against a reference model, starting from the wide state
    mAnd = 8'h30; mOr = 8'hFC; mNot = 8'h0F; mXor = 8'hCC;
    mNand = 8'hCF; mNor = 8'h03; mXnor = 8'h33; mValid = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      ren = 1'($urandom_range(0, 3) != 0);
      a8 = ra; b8 = rb; en8 = ren;
      tick();
      if (ren) begin
        mAnd  = ra & rb;
        mOr   = ra | rb;
        mNot  = ~ra;
        mNand = ~(ra & rb);
        mNor  = ~(ra | rb);
        mXor  = ra ^ rb;
        mXnor = ~(ra ^ rb);
        mValid = 1'b1;
      end
      chk("r.and",   32'(and8),   32'(mAnd));
      chk("r.or",    32'(or8),    32'(mOr));
      chk("r.not",   32'(not8),   32'(mNot));
      chk("r.nand",  32'(nand8),  32'(mNand));
      chk("r.nor",   32'(nor8),   32'(mNor));
      chk("r.xor",   32'(xor8),   32'(mXor));
      chk("r.xnor",  32'(xnor8),  32'(mXnor));
      chk("r.valid", 32'(valid8), 32'(mValid));
      if (valid8) begin
        chk("inv.nand", 32'(nand8), 32'(8'(~and8)));
        chk("inv.nor",  32'(nor8),  32'(8'(~or8)));
        chk("inv.xnor", 32'(xnor8), 32'(8'(~xor8)));
        chk("inv.xor",  32'(xor8),  32'(8'(or8 & ~and8)));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
